// File: rtl/solver_timer_pkg.sv
// Shared definitions for the solver interval-timer command controller.
// Opcodes, timer register map, control bit positions and controller states.
package solver_timer_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_START = 2'b00,
        OP_STOP       = 2'b01,
        OP_SNAPSHOT   = 2'b10,
        OP_CLEAR      = 2'b11
    } cmd_op_e;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CTRL     = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;

    localparam int CTRL_STOP  = 3;
    localparam int CTRL_START = 2;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_IE    = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_CSTOP,
        ST_W_PL,
        ST_W_PH,
        ST_W_STAT,
        ST_W_CSTART,
        ST_W_STOP,
        ST_W_CLR,
        ST_W_SNAP,
        ST_R_LO,
        ST_R_HI,
        ST_R_CAP
    } state_e;

endpackage

// File: rtl/solver_timer_ctrl_if.sv
// Command port plus timer s1 master port of the solver timer controller.
// slave = controller view, master = requester/timer environment view.
interface solver_timer_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [31:0]       cmd_period;
    logic              cmd_cont;
    logic              cmd_irq_en;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              busy;
    logic [ADDR_W-1:0] tmr_address;
    logic              tmr_chipselect;
    logic              tmr_write_n;
    logic [DATA_W-1:0] tmr_writedata;
    logic [DATA_W-1:0] tmr_readdata;

    modport slave (
        input  cmd_valid, cmd_op, cmd_period, cmd_cont, cmd_irq_en, tmr_readdata,
        output cmd_ready, rsp_valid, rsp_data, busy,
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
    );

    modport master (
        output cmd_valid, cmd_op, cmd_period, cmd_cont, cmd_irq_en, tmr_readdata,
        input  cmd_ready, rsp_valid, rsp_data, busy,
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
    );
endinterface

// File: rtl/solver_timer_ctrl.sv
// Expands timer commands into registered s1 bus cycles; LOAD_START 5, STOP/CLEAR 1, SNAPSHOT 4 cycles to ready.
// One command at a time, no queue: cmd_ready only in IDLE. SNAPSHOT bus sequence needs SOLVER_TIMER_CTRL_SNAPSHOT_EN.
module solver_timer_ctrl
    import solver_timer_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    solver_timer_ctrl_if.slave bus
);

    typedef struct packed {
        logic              cs;
        logic              wr_n;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } tmr_cyc_t;

    localparam tmr_cyc_t CYC_IDLE = '{cs: 1'b0, wr_n: 1'b1, addr: '0, data: '0};

    function automatic tmr_cyc_t wr_cyc(input logic [2:0] addr, input logic [DATA_W-1:0] data);
        tmr_cyc_t c;
        c.cs   = 1'b1;
        c.wr_n = 1'b0;
        c.addr = ADDR_W'(addr);
        c.data = data;
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] ctrl_word(input logic stop, input logic start,
                                                    input logic cont, input logic ie);
        logic [DATA_W-1:0] w;
        w             = '0;
        w[CTRL_STOP]  = stop;
        w[CTRL_START] = start;
        w[CTRL_CONT]  = cont;
        w[CTRL_IE]    = ie;
        return w;
    endfunction

`ifdef SOLVER_TIMER_CTRL_SNAPSHOT_EN
    function automatic tmr_cyc_t rd_cyc(input logic [2:0] addr);
        tmr_cyc_t c;
        c.cs   = 1'b1;
        c.wr_n = 1'b1;
        c.addr = ADDR_W'(addr);
        c.data = '0;
        return c;
    endfunction

    logic [DATA_W-1:0] snap_lo_q;
    logic [31:0]       rsp_data_q;
`else
    logic [DATA_W-1:0] unused_readdata;
    assign unused_readdata = bus.tmr_readdata;
`endif

    state_e      state;
    tmr_cyc_t    cyc_q;
    logic [31:0] period_q;
    logic        cont_q;
    logic        ie_q;
    logic        rsp_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cyc_q       <= CYC_IDLE;
            period_q    <= '0;
            cont_q      <= 1'b0;
            ie_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef SOLVER_TIMER_CTRL_SNAPSHOT_EN
            snap_lo_q   <= '0;
            rsp_data_q  <= '0;
`endif
        end else begin
            cyc_q       <= CYC_IDLE;
            rsp_valid_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        unique case (cmd_op_e'(bus.cmd_op))
                            OP_LOAD_START: begin
                                period_q <= bus.cmd_period;
                                cont_q   <= bus.cmd_cont;
                                ie_q     <= bus.cmd_irq_en;
                                cyc_q    <= wr_cyc(REG_CTRL, ctrl_word(1'b1, 1'b0, bus.cmd_cont, bus.cmd_irq_en));
                                state    <= ST_W_CSTOP;
                            end
                            OP_STOP: begin
                                cyc_q <= wr_cyc(REG_CTRL, ctrl_word(1'b1, 1'b0, cont_q, ie_q));
                                state <= ST_W_STOP;
                            end
                            OP_CLEAR: begin
                                cyc_q <= wr_cyc(REG_STATUS, '0);
                                state <= ST_W_CLR;
                            end
                            OP_SNAPSHOT: begin
`ifdef SOLVER_TIMER_CTRL_SNAPSHOT_EN
                                cyc_q <= wr_cyc(REG_SNAP_L, '0);
                                state <= ST_W_SNAP;
`else
                                rsp_valid_q <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                ST_W_CSTOP: begin
                    cyc_q <= wr_cyc(REG_PERIOD_L, period_q[15:0]);
                    state <= ST_W_PL;
                end
                ST_W_PL: begin
                    cyc_q <= wr_cyc(REG_PERIOD_H, period_q[31:16]);
                    state <= ST_W_PH;
                end
                // Status clear sits between PH and start so the reload-induced stop lands before the start write.
                ST_W_PH: begin
                    cyc_q <= wr_cyc(REG_STATUS, '0);
                    state <= ST_W_STAT;
                end
                ST_W_STAT: begin
                    cyc_q <= wr_cyc(REG_CTRL, ctrl_word(1'b0, 1'b1, cont_q, ie_q));
                    state <= ST_W_CSTART;
                end
`ifdef SOLVER_TIMER_CTRL_SNAPSHOT_EN
                ST_W_SNAP: begin
                    cyc_q <= rd_cyc(REG_SNAP_L);
                    state <= ST_R_LO;
                end
                ST_R_LO: begin
                    cyc_q <= rd_cyc(REG_SNAP_H);
                    state <= ST_R_HI;
                end
                // Timer read data lags the address by one cycle.
                ST_R_HI: begin
                    snap_lo_q <= bus.tmr_readdata;
                    state     <= ST_R_CAP;
                end
                ST_R_CAP: begin
                    rsp_data_q  <= {bus.tmr_readdata, snap_lo_q};
                    rsp_valid_q <= 1'b1;
                    state       <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready      = (state == ST_IDLE);
    assign bus.busy           = (state != ST_IDLE);
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.tmr_chipselect = cyc_q.cs;
    assign bus.tmr_write_n    = cyc_q.wr_n;
    assign bus.tmr_address    = cyc_q.addr;
    assign bus.tmr_writedata  = cyc_q.data;
`ifdef SOLVER_TIMER_CTRL_SNAPSHOT_EN
    assign bus.rsp_data       = rsp_data_q;
`else
    assign bus.rsp_data       = '0;
`endif

endmodule
